// File: rtl/dpram_rd_pkg.sv
// Shared types and constants for the dual-port RAM matrix reader.
package dpram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid FIFO holding {last, data} beats returned by the RAM.
module rd_skid_fifo
    import dpram_rd_pkg::*;
#(
    parameter int W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/dpram_matrix_reader.sv
// Walks a rows x cols matrix in a dual-port RAM and streams it out as valid/ready beats.
// Define DPRAM_RD_TRANSPOSE_EN to add the transpose port for a column-major walk.
module dpram_matrix_reader
    import dpram_rd_pkg::*;
#(
    parameter int DATA = 16,
    parameter int ADDR = 5,
    parameter int DIM  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR-1:0] base,
    input  logic [DIM-1:0]  rows_m1,
    input  logic [DIM-1:0]  cols_m1,
`ifdef DPRAM_RD_TRANSPOSE_EN
    input  logic            transpose,
`endif
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] ram_addr,
    output logic            ram_we,
    output logic [DATA-1:0] ram_din,
    input  logic [DATA-1:0] ram_dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DATA-1:0] m_data,
    output logic            m_last
);

    rd_state_t       state_q;
    logic [ADDR-1:0] addr_q;
    logic [DIM-1:0]  rows_q, cols_q;
    logic [DIM-1:0]  r_q, c_q;
    logic            inflight_q;
    logic            last_inflight_q;
    logic            done_q;
`ifdef DPRAM_RD_TRANSPOSE_EN
    logic            transpose_q;
    logic [ADDR-1:0] col_base_q;
    logic [ADDR-1:0] stride;
    assign stride = ADDR'(cols_q) + ADDR'(1);
`endif

    logic [CNT_W-1:0] fifo_count;
    logic [DATA:0]    fifo_head;
    logic [CNT_W:0]   occ;
    logic             pop, issue, is_final;

    // Occupancy counts the read already in flight so the FIFO can never overflow.
    assign pop      = m_valid & m_ready;
    assign occ      = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue    = (state_q == RUN) && (occ < (CNT_W+1)'(FIFO_DEPTH));
    assign is_final = (r_q == rows_q) && (c_q == cols_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rows_q          <= '0;
            cols_q          <= '0;
            r_q             <= '0;
            c_q             <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            done_q          <= 1'b0;
`ifdef DPRAM_RD_TRANSPOSE_EN
            transpose_q     <= 1'b0;
            col_base_q      <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                last_inflight_q <= is_final;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        addr_q  <= base;
                        rows_q  <= rows_m1;
                        cols_q  <= cols_m1;
                        r_q     <= '0;
                        c_q     <= '0;
`ifdef DPRAM_RD_TRANSPOSE_EN
                        transpose_q <= transpose;
                        col_base_q  <= base;
`endif
                    end
                end
                RUN: begin
                    if (issue) begin
`ifdef DPRAM_RD_TRANSPOSE_EN
                        if (transpose_q) begin
                            if (r_q == rows_q) begin
                                r_q        <= '0;
                                c_q        <= c_q + DIM'(1);
                                addr_q     <= col_base_q + ADDR'(1);
                                col_base_q <= col_base_q + ADDR'(1);
                            end else begin
                                r_q    <= r_q + DIM'(1);
                                addr_q <= addr_q + stride;
                            end
                        end else
`endif
                        begin
                            addr_q <= addr_q + ADDR'(1);
                            if (c_q == cols_q) begin
                                c_q <= '0;
                                r_q <= r_q + DIM'(1);
                            end else begin
                                c_q <= c_q + DIM'(1);
                            end
                        end
                        if (is_final) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    rd_skid_fifo #(
        .W(DATA + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({last_inflight_q, ram_dout}),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign m_valid  = (fifo_count != '0);
    assign m_data   = fifo_head[DATA-1:0];
    assign m_last   = m_valid & fifo_head[DATA];

endmodule

// File: tb/tb_dpram_matrix_reader.sv
// Scoreboard bench for dpram_matrix_reader: directed commands against a registered-read RAM model.
module tb_dpram_matrix_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  base;
    logic [2:0]  rows_m1, cols_m1;
`ifdef DPRAM_RD_TRANSPOSE_EN
    logic        transpose;
`endif
    logic        busy, done;
    logic [4:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;

    dpram_matrix_reader #(.DATA(16), .ADDR(5), .DIM(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .rows_m1  (rows_m1),
        .cols_m1  (cols_m1),
`ifdef DPRAM_RD_TRANSPOSE_EN
        .transpose(transpose),
`endif
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [32];
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int checks   = 0;
    int failures = 0;
    logic [16:0] sb [$];
    bit alt_mode = 1'b0;

    always @(posedge clk) begin
        #1;
        m_ready = alt_mode ? ~m_ready : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input bit l);
        sb.push_back({l, 16'(d)});
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability and the done pulse.
    int          done_wait = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            done_wait  = 0;
        end else begin
            if (done_wait == 1) begin
                chk("done_pulse", done, 1);
                chk("busy_after_done", busy, 0);
                done_wait = 2;
            end else if (done_wait == 2) begin
                chk("done_one_cycle", done, 0);
                done_wait = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat_queue", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    $display("beat data=%0d last=%0b exp_data=%0d exp_last=%0b", m_data, m_last, e[15:0], e[16]);
                    chk("beat_data", m_data, e[15:0]);
                    chk("beat_last", m_last, e[16]);
                    if (e[16]) done_wait = 1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic run_cmd(input logic [4:0] b, input logic [2:0] r, input logic [2:0] c,
                           input bit tr, input int exp_cycles, input int mid_start, input string name);
        int k;
        bit got;
        @(posedge clk); #1;
        start = 1'b1; base = b; rows_m1 = r; cols_m1 = c;
`ifdef DPRAM_RD_TRANSPOSE_EN
        transpose = tr;
`else
        if (tr) $display("note: transpose request ignored in this build");
`endif
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_busy"}, busy, 1);
        chk({name, "_first_addr"}, ram_addr, b);
        k = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            if (k == mid_start) begin
                start = 1'b1; base = 5'd0; rows_m1 = 3'd0; cols_m1 = 3'd0;
            end else if (k == mid_start + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (done) got = 1'b1;
        end
        chk({name, "_done_seen"}, got, 1);
        if (exp_cycles > 0) chk({name, "_cycles"}, k, exp_cycles);
        chk({name, "_sb_empty"}, sb.size(), 0);
        $display("cmd %s base=%0d rows_m1=%0d cols_m1=%0d cycles=%0d", name, b, r, c, k);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'(3 * i);
        rst_n = 1'b0; start = 1'b0; base = '0; rows_m1 = '0; cols_m1 = '0;
`ifdef DPRAM_RD_TRANSPOSE_EN
        transpose = 1'b0;
`endif
        #12;
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        push(12, 0); push(15, 0); push(18, 0); push(21, 0); push(24, 0); push(27, 1);
        run_cmd(5'd4, 3'd1, 3'd2, 1'b0, 8, -1, "rowmajor");

        alt_mode = 1'b1;
        push(12, 0); push(15, 0); push(18, 0); push(21, 0); push(24, 0); push(27, 1);
        run_cmd(5'd4, 3'd1, 3'd2, 1'b0, -1, -1, "stall");
        alt_mode = 1'b0;

        push(90, 0); push(93, 0); push(0, 0); push(3, 1);
        run_cmd(5'd30, 3'd0, 3'd3, 1'b0, 6, -1, "wrap");

`ifdef DPRAM_RD_TRANSPOSE_EN
        push(0, 0); push(9, 0); push(3, 0); push(12, 0); push(6, 0); push(15, 1);
        run_cmd(5'd0, 3'd1, 3'd2, 1'b1, 8, -1, "transpose");
`endif

        push(12, 0); push(15, 0); push(18, 0); push(21, 0); push(24, 0); push(27, 1);
        run_cmd(5'd4, 3'd1, 3'd2, 1'b0, 8, 3, "midstart");

        push(12, 0); push(15, 0); push(18, 0); push(21, 0); push(24, 0); push(27, 1);
        @(posedge clk); #1;
        start = 1'b1; base = 5'd4; rows_m1 = 3'd1; cols_m1 = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_m_last", m_last, 0);
        $display("abort mid-stream, %0d beats dropped from scoreboard", sb.size());
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        push(21, 1);
        run_cmd(5'd7, 3'd0, 3'd0, 1'b0, 3, -1, "single");

        alt_mode = 1'b1;
        push(30, 0); push(33, 0); push(36, 1);
        run_cmd(5'd10, 3'd2, 3'd0, 1'b0, -1, -1, "column");
        alt_mode = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
